y86_fetch_stage: RTL and testbench

- Y86-64 pipeline fetch stage: combinational instruction fetch/decode from an internal byte-addressed instruction memory, next-PC prediction, and the F pipeline register holding the predicted PC.
- Sits at the front of the pipeline. PC selection (mispredict/ret recovery) is external and drives `PC`. `f_pc` feeds back to that selection logic.

---
 rtl/y86_fetch_stage.sv | 129 ++++++++++++
 tb/tb_y86_fetch_stage.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/y86_fetch_stage.sv
// Y86-64 fetch stage: combinational fetch/decode from a byte-wide instruction
// memory, next-PC prediction, and the F register holding the predicted PC.
module y86_fetch_stage #(
  parameter int IMEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] PC,
  input  logic        f_stall,
  input  logic        imem_we,
  input  logic [63:0] imem_addr,
  input  logic [7:0]  imem_wdata,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [63:0] valC,
  output logic [63:0] valP,
  output logic [63:0] predicted_pc,
  output logic [63:0] f_pc,
  output logic        instr_valid,
  output logic        imem_error
);

  localparam int          AW      = (IMEM_BYTES > 1) ? $clog2(IMEM_BYTES) : 1;
  localparam logic [63:0] MEM_TOP = 64'(IMEM_BYTES);

  logic [7:0]  r_mem [IMEM_BYTES];
  logic [63:0] r_f_pc;
  logic [63:0] w_addr [10];
  logic [7:0]  w_byte [10];
  logic [9:0]  w_oor;
  logic [9:0]  w_need;
  logic [3:0]  w_len;
  logic        w_has_reg;
  logic [1:0]  w_c_off;

  // Program-load write port; contents are deliberately not touched by reset.
  always_ff @(posedge clk) begin
    if (imem_we && (imem_addr < MEM_TOP)) begin
      r_mem[imem_addr[AW-1:0]] <= imem_wdata;
    end
  end

  // Read the longest possible instruction window; out-of-range bytes read as zero.
  always_comb begin
    for (int k = 0; k < 10; k++) begin
      w_addr[k] = PC + 64'(k);
      if (w_addr[k] < MEM_TOP) begin
        w_byte[k] = r_mem[w_addr[k][AW-1:0]];
        w_oor[k]  = 1'b0;
      end else begin
        w_byte[k] = 8'h00;
        w_oor[k]  = 1'b1;
      end
    end
  end

  assign icode = w_byte[0][7:4];
  assign ifun  = w_byte[0][3:0];

  // Instruction length and field layout per icode; illegal codes behave as 1-byte.
  always_comb begin
    w_len       = 4'd1;
    w_has_reg   = 1'b0;
    w_c_off     = 2'd0;
    instr_valid = 1'b1;
    case (icode)
      4'h0, 4'h1, 4'h9: begin
        w_len = 4'd1;
      end
      4'h2, 4'h6, 4'hA, 4'hB: begin
        w_len     = 4'd2;
        w_has_reg = 1'b1;
      end
      4'h3, 4'h4, 4'h5: begin
        w_len     = 4'd10;
        w_has_reg = 1'b1;
        w_c_off   = 2'd2;
      end
      4'h7, 4'h8: begin
        w_len   = 4'd9;
        w_c_off = 2'd1;
      end
      default: begin
        instr_valid = 1'b0;
      end
    endcase
  end

  // Register specifiers and little-endian constant extraction.
  always_comb begin
    rA   = 4'hF;
    rB   = 4'hF;
    valC = 64'd0;
    if (w_has_reg) begin
      rA = w_byte[1][7:4];
      rB = w_byte[1][3:0];
    end else begin
      rA = 4'hF;
      rB = 4'hF;
    end
    case (w_c_off)
      2'd1:    valC = {w_byte[8], w_byte[7], w_byte[6], w_byte[5],
                       w_byte[4], w_byte[3], w_byte[2], w_byte[1]};
      2'd2:    valC = {w_byte[9], w_byte[8], w_byte[7], w_byte[6],
                       w_byte[5], w_byte[4], w_byte[3], w_byte[2]};
      default: valC = 64'd0;
    endcase
  end

  // Only bytes inside the decoded length can raise an error (len 10 wraps the mask to all ones).
  assign w_need       = (10'd1 << w_len) - 10'd1;
  assign imem_error   = |(w_oor & w_need);
  assign valP         = PC + {60'd0, w_len};
  assign predicted_pc = ((icode == 4'h7) || (icode == 4'h8)) ? valC : valP;

  // F register: async clear, holds under stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_f_pc <= 64'd0;
    end else if (!f_stall) begin
      r_f_pc <= predicted_pc;
    end
  end

  assign f_pc = r_f_pc;

endmodule

// File: tb/tb_y86_fetch_stage.sv
// Directed bench for y86_fetch_stage: expectations queued per step, then
// drained and compared against the DUT outputs.
module tb_y86_fetch_stage;

  localparam int IMEM_BYTES = 1024;

  logic        clk;
  logic        rst_n;
  logic [63:0] PC;
  logic        f_stall;
  logic        imem_we;
  logic [63:0] imem_addr;
  logic [7:0]  imem_wdata;
  logic [3:0]  icode, ifun, rA, rB;
  logic [63:0] valC, valP, predicted_pc, f_pc;
  logic        instr_valid, imem_error;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } exp_t;
  exp_t sb[$];

  y86_fetch_stage #(.IMEM_BYTES(IMEM_BYTES)) dut (
    .clk(clk), .rst_n(rst_n), .PC(PC), .f_stall(f_stall),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .icode(icode), .ifun(ifun), .rA(rA), .rB(rB), .valC(valC), .valP(valP),
    .predicted_pc(predicted_pc), .f_pc(f_pc),
    .instr_valid(instr_valid), .imem_error(imem_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [63:0] obs_of(input string tag);
    if (tag == "icode")       return {60'd0, icode};
    else if (tag == "ifun")   return {60'd0, ifun};
    else if (tag == "rA")     return {60'd0, rA};
    else if (tag == "rB")     return {60'd0, rB};
    else if (tag == "valC")   return valC;
    else if (tag == "valP")   return valP;
    else if (tag == "pred")   return predicted_pc;
    else if (tag == "f_pc")   return f_pc;
    else if (tag == "valid")  return {63'd0, instr_valid};
    else if (tag == "err")    return {63'd0, imem_error};
    else                      return 64'hxxxx_xxxx_xxxx_xxxx;
  endfunction

  task automatic push(input string tag, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic drain(input string step);
    exp_t        e;
    logic [63:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs_of(e.tag);
      n_tests++;
      assert (o === e.exp) else begin
        n_fail++;
        $error("FAIL %s.%s: observed %0h expected %0h", step, e.tag, o, e.exp);
      end
    end
  endtask

  task automatic wr(input logic [63:0] a, input logic [7:0] d);
    @(negedge clk);
    imem_we    = 1'b1;
    imem_addr  = a;
    imem_wdata = d;
    @(posedge clk);
    #1;
    imem_we = 1'b0;
  endtask

  task automatic load(input logic [63:0] a, input logic [7:0] b [10], input int n);
    for (int i = 0; i < n; i++) wr(a + 64'(i), b[i]);
  endtask

  task automatic set_pc(input logic [63:0] v);
    @(negedge clk);
    PC = v;
    #1;
  endtask

  logic [7:0] prog [10];

  initial begin
    rst_n = 1'b0; PC = 64'd0; f_stall = 1'b0;
    imem_we = 1'b0; imem_addr = 64'd0; imem_wdata = 8'h00;
    #2;
    push("f_pc", 64'd0);
    drain("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // irmovq $10, %rdx
    prog = '{8'h30, 8'hF2, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    load(64'h0, prog, 10);
    set_pc(64'h0);
    push("icode", 64'h3); push("ifun", 64'h0); push("rA", 64'hF); push("rB", 64'h2);
    push("valC", 64'd10); push("valP", 64'd10); push("pred", 64'd10);
    push("valid", 64'h1); push("err", 64'h0);
    drain("irmovq");
    @(posedge clk); #1;
    push("f_pc", 64'd10);
    drain("irmovq_fpc");

    // jmp 0x100, je 0x100, call 0x100
    prog = '{8'h70, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    load(64'h20, prog, 9);
    set_pc(64'h20);
    push("icode", 64'h7); push("rA", 64'hF); push("rB", 64'hF);
    push("valC", 64'h100); push("valP", 64'h29); push("pred", 64'h100);
    drain("jmp");
    wr(64'h20, 8'h73);
    set_pc(64'h20);
    push("ifun", 64'h3); push("pred", 64'h100); push("valP", 64'h29);
    drain("je");
    prog = '{8'h80, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    load(64'h30, prog, 9);
    set_pc(64'h30);
    push("icode", 64'h8); push("valC", 64'h100); push("valP", 64'h39); push("pred", 64'h100);
    drain("call");

    // remaining encodings at 0x40
    wr(64'h40, 8'h60); wr(64'h41, 8'h23);
    set_pc(64'h40);
    push("icode", 64'h6); push("rA", 64'h2); push("rB", 64'h3); push("valC", 64'h0);
    push("valP", 64'h42); push("pred", 64'h42); push("valid", 64'h1);
    drain("addq");
    wr(64'h40, 8'h90);
    set_pc(64'h40);
    push("icode", 64'h9); push("rA", 64'hF); push("rB", 64'hF); push("valP", 64'h41); push("pred", 64'h41);
    drain("ret");
    wr(64'h40, 8'h00);
    set_pc(64'h40);
    push("icode", 64'h0); push("valP", 64'h41); push("err", 64'h0); push("valid", 64'h1);
    drain("halt");
    wr(64'h40, 8'hA0); wr(64'h41, 8'h6F);
    set_pc(64'h40);
    push("icode", 64'hA); push("rA", 64'h6); push("rB", 64'hF); push("valP", 64'h42);
    drain("pushq");
    prog = '{8'h50, 8'h12, 8'h18, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    load(64'h40, prog, 10);
    set_pc(64'h40);
    push("icode", 64'h5); push("rA", 64'h1); push("rB", 64'h2);
    push("valC", 64'h18); push("valP", 64'h4A); push("pred", 64'h4A);
    drain("mrmovq");

    // illegal opcode
    wr(64'h50, 8'hF0);
    set_pc(64'h50);
    push("icode", 64'hF); push("valid", 64'h0); push("rA", 64'hF); push("rB", 64'hF);
    push("valC", 64'h0); push("valP", 64'h51); push("pred", 64'h51); push("err", 64'h0);
    drain("illegal");

    // memory edge
    wr(64'(IMEM_BYTES - 2), 8'h30); wr(64'(IMEM_BYTES - 1), 8'hF2);
    set_pc(64'(IMEM_BYTES - 2));
    push("icode", 64'h3); push("err", 64'h1); push("rB", 64'h2); push("valC", 64'h0);
    push("valP", 64'(IMEM_BYTES + 8));
    drain("irmovq_edge");
    set_pc(64'(IMEM_BYTES - 1));
    push("icode", 64'hF); push("err", 64'h0); push("valP", 64'(IMEM_BYTES));
    drain("last_byte");
    set_pc(64'(IMEM_BYTES));
    push("icode", 64'h0); push("err", 64'h1); push("valP", 64'(IMEM_BYTES + 1));
    drain("oor_byte0");

    // out-of-range write must not alias onto address 0
    wr(64'(IMEM_BYTES), 8'h90);
    set_pc(64'h0);
    push("icode", 64'h3); push("valP", 64'd10);
    drain("oor_write");

    // reset and stall
    set_pc(64'h20);
    @(posedge clk); #1;
    push("f_pc", 64'h100);
    drain("run_to_100");
    #2;
    rst_n = 1'b0;
    PC = 64'h0;
    #1;
    push("f_pc", 64'h0);
    drain("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    push("f_pc", 64'd10);
    drain("reset_release");
    @(negedge clk);
    f_stall = 1'b1;
    PC = 64'h20;
    @(posedge clk); #1;
    push("f_pc", 64'd10);
    drain("stall1");
    @(posedge clk); #1;
    push("f_pc", 64'd10);
    drain("stall2");
    @(negedge clk);
    f_stall = 1'b0;
    @(posedge clk); #1;
    push("f_pc", 64'h100);
    drain("unstall");

    // overwrite the byte being fetched
    @(negedge clk);
    PC = 64'h0;
    imem_we = 1'b1; imem_addr = 64'h0; imem_wdata = 8'h10;
    #1;
    push("icode", 64'h3);
    drain("pre_write");
    @(posedge clk); #1;
    imem_we = 1'b0;
    push("icode", 64'h1); push("valP", 64'h1); push("pred", 64'h1);
    drain("post_write");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
